// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative HI/LO multiply/divide unit that sits beside the ALU.
// It does a radix-2 shift-add multiply and a restoring divide, producing one
// result bit per cycle, with optional signed operation and MTHI/MTLO writes.
module sm_muldiv #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wData,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // One extra counter bit lets the counter reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               isDiv_q, isDiv_d;
  logic               negLo_q, negLo_d;
  logic               negHi_q, negHi_d;
  logic               zeroDiv_q, zeroDiv_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   rawA_q, rawA_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divZero_q, divZero_d;

  logic               signedOp;
  logic               signA, signB;
  logic [WIDTH-1:0]   magA, magB;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH:0]   divShift;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  // Operand signs and magnitudes; the iterative core only ever sees magnitudes.
  always_comb begin
    signedOp = SIGNED_EN && !op[0];
    signA    = signedOp && srcA[WIDTH-1];
    signB    = signedOp && srcB[WIDTH-1];
    magA     = signA ? -srcA : srcA;
    magB     = signB ? -srcB : srcB;
  end

  // One iteration step: conditional add-then-shift-right for multiply,
  // shift-left-then-trial-subtract for divide (remainder needs a carry bit).
  always_comb begin
    mulSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      mulSum = mulSum + {1'b0, opnd_q};
    end
    mulNext  = {mulSum, acc_q[WIDTH-1:1]};
    divShift = {acc_q, 1'b0};
    divTrial = divShift[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    if (divTrial[WIDTH]) begin
      divNext = divShift[2*WIDTH-1:0];
    end else begin
      divNext = {divTrial[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};
    end
  end

  // Sign correction applied to the unsigned result during FIX.
  always_comb begin
    prodFix = negLo_q ? -acc_q : acc_q;
    quotFix = negLo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    remFix  = negHi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Control: launch from IDLE (start beats MTHI/MTLO), iterate in RUN, load HI/LO in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    negLo_d   = negLo_q;
    negHi_d   = negHi_q;
    zeroDiv_d = zeroDiv_q;
    opnd_d    = opnd_q;
    rawA_d    = rawA_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divZero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          isDiv_d   = op[1];
          negLo_d   = signA ^ signB;
          negHi_d   = op[1] && signA;
          zeroDiv_d = op[1] && (srcB == '0);
          rawA_d    = srcA;
          if (op[1]) begin
            opnd_d = magB;
            acc_d  = {{WIDTH{1'b0}}, magA};
          end else begin
            opnd_d = magA;
            acc_d  = {{WIDTH{1'b0}}, magB};
          end
        end else begin
          if (hiWe) begin
            hi_d = wData;
          end
          if (loWe) begin
            lo_d = wData;
          end
        end
      end
      RUN: begin
        acc_d = isDiv_q ? divNext : mulNext;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        divZero_d = isDiv_q && zeroDiv_q;
        if (!isDiv_q) begin
          {hi_d, lo_d} = prodFix;
        end else if (zeroDiv_q) begin
          lo_d = '1;
          hi_d = rawA_q;
        end else begin
          lo_d = quotFix;
          hi_d = remFix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; an aborted operation leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      zeroDiv_q <= 1'b0;
      opnd_q    <= '0;
      rawA_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      negLo_q   <= negLo_d;
      negHi_q   <= negHi_d;
      zeroDiv_q <= zeroDiv_d;
      opnd_q    <= opnd_d;
      rawA_q    <= rawA_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divZero_q <= divZero_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divZero = divZero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: scoreboard bench for sm_muldiv. Three instances cover the
// 32-bit signed, 8-bit signed and 32-bit unsigned-only configurations; they
// are exercised one after another so a single expectation queue serves all.
module tb_sm_muldiv;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    longint      cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [31:0] srcA, srcB, wData;
  logic        startV [3];
  logic        hiWeV  [3];
  logic        loWeV  [3];
  wire         busyV  [3];
  wire         doneV  [3];
  wire         dzV    [3];
  wire  [31:0] hiV    [3];
  wire  [31:0] loV    [3];
  wire  [7:0]  hi8, lo8;

  logic [31:0] curHi [3];
  logic [31:0] curLo [3];
  exp_t        sbq [$];
  longint      cyc = 0;
  int          nCompared = 0;
  int          nMismatch = 0;

  sm_muldiv #(.WIDTH(32), .SIGNED_EN(1'b1)) u32s (
    .clk(clk), .rst(rst), .start(startV[0]), .op(op), .srcA(srcA), .srcB(srcB),
    .hiWe(hiWeV[0]), .loWe(loWeV[0]), .wData(wData), .busy(busyV[0]),
    .done(doneV[0]), .divZero(dzV[0]), .hi(hiV[0]), .lo(loV[0]));

  sm_muldiv #(.WIDTH(8), .SIGNED_EN(1'b1)) u8s (
    .clk(clk), .rst(rst), .start(startV[1]), .op(op), .srcA(srcA[7:0]), .srcB(srcB[7:0]),
    .hiWe(hiWeV[1]), .loWe(loWeV[1]), .wData(wData[7:0]), .busy(busyV[1]),
    .done(doneV[1]), .divZero(dzV[1]), .hi(hi8), .lo(lo8));

  assign hiV[1] = {24'h0, hi8};
  assign loV[1] = {24'h0, lo8};

  sm_muldiv #(.WIDTH(32), .SIGNED_EN(1'b0)) u32u (
    .clk(clk), .rst(rst), .start(startV[2]), .op(op), .srcA(srcA), .srcB(srcB),
    .hiWe(hiWeV[2]), .loWe(loWeV[2]), .wData(wData), .busy(busyV[2]),
    .done(doneV[2]), .divZero(dzV[2]), .hi(hiV[2]), .lo(loV[2]));

  // Free-running clock and a cycle count used to check result latency.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wOf(input int i);
    return (i == 1) ? 8 : 32;
  endfunction

  function automatic bit sEnOf(input int i);
    return (i != 2);
  endfunction

  task automatic checkOutput(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s (dut %0d): got %0h, expected %0h", name, i, act, exp);
    end
  endtask

  task automatic reportFail(input string name, input int i);
    nCompared++;
    nMismatch++;
    $display("[TB] FAIL %s (dut %0d): event not as required", name, i);
  endtask

  // Reference model: plain integer arithmetic on the operands as numbers.
  function automatic exp_t model(input int i, input logic [1:0] opc, input logic [31:0] a, input logic [31:0] b);
    int          w;
    bit          sOp;
    logic [63:0] mask, ua, ub, p, q, r;
    longint      sa, sb;
    exp_t        e;
    w    = wOf(i);
    sOp  = sEnOf(i) && !opc[0];
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'h0, a} & mask;
    ub   = {32'h0, b} & mask;
    sa   = longint'(ua);
    sb   = longint'(ub);
    if (sOp && ua[w-1]) sa = sa - (longint'(1) << w);
    if (sOp && ub[w-1]) sb = sb - (longint'(1) << w);
    e.dz  = 1'b0;
    e.cyc = 0;
    if (!opc[1]) begin
      if (sOp) p = sa * sb;
      else     p = ua * ub;
      e.hi = 32'((p >> w) & mask);
      e.lo = 32'(p & mask);
    end else if (ub == 64'd0) begin
      e.lo = 32'(mask);
      e.hi = 32'(ua);
      e.dz = 1'b1;
    end else begin
      if (sOp) begin
        q = sa / sb;
        r = sa % sb;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      e.lo = 32'(q & mask);
      e.hi = 32'(r & mask);
    end
    return e;
  endfunction

  function automatic logic [31:0] pick(input int i);
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1 << (wOf(i) - 1);
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse pops the oldest expectation and compares it.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (doneV[i]) begin
        if (sbq.size() == 0) begin
          reportFail("unexpected_done", i);
        end else begin
          e = sbq.pop_front();
          checkOutput("result_hi", i, hiV[i], e.hi);
          checkOutput("result_lo", i, loV[i], e.lo);
          checkOutput("divZero", i, dzV[i], e.dz);
          checkOutput("done_cycle", i, cyc, e.cyc);
        end
      end else if (dzV[i]) begin
        reportFail("divZero_without_done", i);
      end
    end
  end

  // Issue one operation, optionally poking start/MTHI/MTLO while busy, and wait for done.
  task automatic applyStimulus(input int i, input logic [1:0] opc, input logic [31:0] a,
                               input logic [31:0] b, input bit poke, input bit withWrite);
    exp_t e;
    int   k;
    e     = model(i, opc, a, b);
    e.cyc = cyc + wOf(i) + 2;
    sbq.push_back(e);
    startV[i] = 1'b1;
    op        = opc;
    srcA      = a;
    srcB      = b;
    if (withWrite) begin
      hiWeV[i] = 1'b1;
      loWeV[i] = 1'b1;
      wData    = $urandom;
    end
    @(negedge clk);
    startV[i] = 1'b0;
    hiWeV[i]  = 1'b0;
    loWeV[i]  = 1'b0;
    op        = 2'($urandom_range(0, 3));
    srcA      = $urandom;
    srcB      = $urandom;
    checkOutput("busy_after_start", i, busyV[i], 1);
    checkOutput("hi_held_in_run", i, hiV[i], curHi[i]);
    checkOutput("lo_held_in_run", i, loV[i], curLo[i]);
    if (poke) begin
      startV[i] = 1'b1;
      hiWeV[i]  = 1'b1;
      loWeV[i]  = 1'b1;
      wData     = 32'hDEAD_BEEF;
      @(negedge clk);
      startV[i] = 1'b0;
      hiWeV[i]  = 1'b0;
      loWeV[i]  = 1'b0;
      checkOutput("hi_write_while_busy", i, hiV[i], curHi[i]);
      checkOutput("lo_write_while_busy", i, loV[i], curLo[i]);
    end
    k = 0;
    while (!doneV[i] && k < wOf(i) + 8) begin
      @(negedge clk);
      k++;
    end
    if (!doneV[i]) reportFail("done_timeout", i);
    else checkOutput("busy_in_done_cycle", i, busyV[i], 0);
    curHi[i] = e.hi;
    curLo[i] = e.lo;
  endtask

  task automatic mtWrite(input int i, input bit wh, input bit wl, input logic [31:0] d);
    logic [31:0] m;
    m        = 32'((64'd1 << wOf(i)) - 64'd1);
    hiWeV[i] = wh;
    loWeV[i] = wl;
    wData    = d;
    @(negedge clk);
    hiWeV[i] = 1'b0;
    loWeV[i] = 1'b0;
    wData    = ~d;
    if (wh) curHi[i] = d & m;
    if (wl) curLo[i] = d & m;
    checkOutput("mt_hi", i, hiV[i], curHi[i]);
    checkOutput("mt_lo", i, loV[i], curLo[i]);
  endtask

  // Abort a MULTU with reset partway through; no done may follow.
  task automatic resetMid(input int i);
    int at;
    at        = (wOf(i) == 8) ? 5 : 10;
    startV[i] = 1'b1;
    op        = OP_MULTU;
    srcA      = 32'hFFFF_FFFF;
    srcB      = 32'hFFFF_FFFF;
    @(negedge clk);
    startV[i] = 1'b0;
    repeat (at - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      curHi[j] = '0;
      curLo[j] = '0;
    end
    checkOutput("abort_busy", i, busyV[i], 0);
    checkOutput("abort_hi", i, hiV[i], 0);
    checkOutput("abort_lo", i, loV[i], 0);
    for (int n = 0; n < wOf(i) + 4; n++) begin
      @(negedge clk);
      checkOutput("no_done_after_abort", i, doneV[i], 0);
    end
  endtask

  task automatic runSuite(input int i);
    logic [1:0]  opc;
    logic [31:0] a, b, mostNeg;
    mostNeg = 32'd1 << (wOf(i) - 1);
    applyStimulus(i, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(i, OP_MULT,  32'hFFFF_FFFD, 32'h5, 0, 0);
    applyStimulus(i, OP_DIV,   32'hFFFF_FFF9, 32'h2, 0, 0);
    applyStimulus(i, OP_DIVU,  32'h64, 32'h7, 0, 0);
    applyStimulus(i, OP_DIVU,  32'h5, 32'h0, 0, 0);
    applyStimulus(i, OP_DIV,   mostNeg, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(i, OP_DIV,   32'hFFFF_FFF9, 32'h0, 0, 0);
    applyStimulus(i, OP_MULT,  32'h7, 32'hFFFF_FFFE, 0, 0);
    @(negedge clk);
    mtWrite(i, 1, 0, 32'h1234_5678);
    mtWrite(i, 0, 1, 32'h9ABC_DEF0);
    mtWrite(i, 1, 1, $urandom);
    applyStimulus(i, OP_MULT, 32'h3, 32'h3, 1, 1);
    for (int n = 0; n < 20; n++) begin
      opc = 2'($urandom_range(0, 3));
      a   = pick(i);
      b   = pick(i);
      applyStimulus(i, opc, a, b, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    resetMid(i);
  endtask

  // Main sequence: reset, check reset state, run each configuration in turn.
  initial begin
    rst   = 1'b1;
    op    = '0;
    srcA  = '0;
    srcB  = '0;
    wData = '0;
    for (int j = 0; j < 3; j++) begin
      startV[j] = 1'b0;
      hiWeV[j]  = 1'b0;
      loWeV[j]  = 1'b0;
      curHi[j]  = '0;
      curLo[j]  = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checkOutput("reset_busy", j, busyV[j], 0);
      checkOutput("reset_done", j, doneV[j], 0);
      checkOutput("reset_divZero", j, dzV[j], 0);
      checkOutput("reset_hi", j, hiV[j], 0);
      checkOutput("reset_lo", j, loV[j], 0);
    end
    for (int j = 0; j < 3; j++) begin
      $display("[TB] running configuration %0d (WIDTH=%0d)", j, wOf(j));
      runSuite(j);
    end
    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", 0, sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  // Watchdog so a stuck DUT can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] stopped by watchdog");
  end

endmodule
